instr_mem_loader: RTL and testbench

- Parametrised, writable successor to the fixed instruction lookup table. Holds 2**D words of W-bit machine code.
- A program is streamed in at run time over a valid/ready load port. After loading, the block serves registered, stallable fetches to the fetch stage.
- Tracks program length. Out-of-range fetches and fetches before a program is loaded return a configurable NOP instead of stale contents.

---
 rtl/instr_mem_loader.sv | 138 +++++++++++++
 tb/tb_instr_mem_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Writable instruction store: a program is streamed in over a valid/ready port,
// then served as registered, stallable fetches with NOP for anything outside it.
module instr_mem_loader #(
  parameter int           D   = 12,
  parameter int           W   = 9,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  output logic         load_ready,
  output logic [D:0]   prog_len,
  output logic         prog_loaded,
  output logic         load_ovf,
  input  logic [D-1:0] prog_ctr_out,
  input  logic         fetch_en,
  input  logic         stall,
  output logic [W-1:0] mach_code,
  output logic         fetch_valid,
  output logic         fetch_oob
);
  localparam int DEPTH = 2**D;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t       state_q, state_d;
  logic [D:0]   cnt_q, cnt_d;
  logic [D:0]   len_q, len_d;
  logic         loaded_q, loaded_d;
  logic         ovf_q, ovf_d;
  logic         ready_q, ready_d;
  logic [W-1:0] mc_q, mc_d;
  logic         fv_q, fv_d;
  logic         fo_q, fo_d;

  logic [W-1:0] mem_q [DEPTH];

  logic         accept;
  logic         at_top;
  logic         in_range;
  logic [W-1:0] rd_word;

  always_comb begin
    // a start pulse wins over a word arriving in the same cycle
    accept   = (state_q == LOAD) && load_valid && !load_start;
    at_top   = (cnt_q == (D+1)'(DEPTH-1));
    in_range = ({1'b0, prog_ctr_out} < len_q);
    rd_word  = mem_q[prog_ctr_out];

    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    ready_d  = ready_q;
    mc_d     = mc_q;
    fv_d     = fv_q;
    fo_d     = fo_q;

    if (load_start) begin
      state_d  = LOAD;
      cnt_d    = '0;
      len_d    = '0;
      loaded_d = 1'b0;
      ovf_d    = 1'b0;
      ready_d  = 1'b1;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      len_d = cnt_q + 1'b1;
      if (load_last || at_top) begin
        state_d  = READY;
        loaded_d = 1'b1;
        ovf_d    = !load_last;
        ready_d  = 1'b0;
      end
    end

    if (load_start) begin
      mc_d = NOP;
      fv_d = 1'b0;
      fo_d = 1'b0;
    end else if (!stall) begin
      if (fetch_en) begin
        if (state_q == READY) begin
          mc_d = in_range ? rd_word : NOP;
          fv_d = 1'b1;
          fo_d = !in_range;
        end else begin
          mc_d = NOP;
          fv_d = 1'b0;
          fo_d = 1'b0;
        end
      end else begin
        fv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      len_q    <= '0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      mc_q     <= NOP;
      fv_q     <= 1'b0;
      fo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      mc_q     <= mc_d;
      fv_q     <= fv_d;
      fo_q     <= fo_d;
    end
  end

  // contents survive reset; only the length bookkeeping is cleared
  always_ff @(posedge clk) begin
    if (reset_n && accept) mem_q[cnt_q[D-1:0]] <= load_data;
  end

  assign load_ready  = ready_q;
  assign prog_len    = len_q;
  assign prog_loaded = loaded_q;
  assign load_ovf    = ovf_q;
  assign mach_code   = mc_q;
  assign fetch_valid = fv_q;
  assign fetch_oob   = fo_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: a cycle-level behavioural model is
// compared against every output each cycle, plus hand-computed spot checks.
module tb_instr_mem_loader;
  localparam int D = 12;
  localparam int W = 9;
  localparam int DEPTH = 2**D;
  localparam logic [W-1:0] NOP = '0;

  logic         clk = 0;
  logic         reset_n = 0;
  logic         load_start = 0, load_valid = 0, load_last = 0;
  logic [W-1:0] load_data = '0;
  logic         load_ready;
  logic [D:0]   prog_len;
  logic         prog_loaded, load_ovf;
  logic [D-1:0] prog_ctr_out = '0;
  logic         fetch_en = 0, stall = 0;
  logic [W-1:0] mach_code;
  logic         fetch_valid, fetch_oob;

  instr_mem_loader #(.D(D), .W(W), .NOP(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .prog_len(prog_len), .prog_loaded(prog_loaded), .load_ovf(load_ovf),
    .prog_ctr_out(prog_ctr_out), .fetch_en(fetch_en), .stall(stall),
    .mach_code(mach_code), .fetch_valid(fetch_valid), .fetch_oob(fetch_oob)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 0, rnd = 0;
  logic [W-1:0] prog [DEPTH];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a program is a list of words; "loading" means we are collecting one,
  // "loaded" means a complete one is resident and fetches are served from it.
  bit           m_loading, m_loaded, m_ovf, m_fv, m_fo;
  int           m_len;
  logic [W-1:0] m_mc;
  logic [W-1:0] m_mem [int];

  always @(posedge clk) begin
    if (!reset_n) begin
      m_loading = 0; m_loaded = 0; m_ovf = 0; m_len = 0;
      m_mc = NOP; m_fv = 0; m_fo = 0;
    end else begin
      if (load_start) begin
        m_mc = NOP; m_fv = 0; m_fo = 0;
      end else if (!stall) begin
        if (fetch_en && m_loaded) begin
          m_fv = 1;
          m_fo = (int'(prog_ctr_out) >= m_len);
          m_mc = m_fo ? NOP : m_mem[int'(prog_ctr_out)];
        end else if (fetch_en) begin
          m_mc = NOP; m_fv = 0; m_fo = 0;
        end else m_fv = 0;
      end
      if (load_start) begin
        m_loading = 1; m_loaded = 0; m_len = 0; m_ovf = 0;
      end else if (m_loading && load_valid) begin
        m_mem[m_len] = load_data;
        m_len++;
        if (load_last || m_len == DEPTH) begin
          m_loading = 0; m_loaded = 1; m_ovf = !load_last;
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("load_ready", int'(load_ready), int'(m_loading));
    chk("prog_len", int'(prog_len), m_len);
    chk("prog_loaded", int'(prog_loaded), int'(m_loaded));
    chk("load_ovf", int'(load_ovf), int'(m_ovf));
    chk("fetch_valid", int'(fetch_valid), int'(m_fv));
    chk("fetch_oob", int'(fetch_oob), int'(m_fo));
    chk("mach_code", int'(mach_code), int'(m_mc));
  end

  task automatic step();
    if (rnd) begin
      fetch_en = 1'($urandom);
      stall = ($urandom_range(3) == 0);
      prog_ctr_out = $urandom_range(1) ? 12'($urandom_range(39)) : 12'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic start_load();
    load_start = 1; step(); load_start = 0;
  endtask

  task automatic load_words(input int n, input bit end_last, input bit bp);
    for (int i = 0; i < n; i++) begin
      while (bp && $urandom_range(2) == 0) begin
        load_valid = 0; load_data = 9'($urandom); step();
      end
      load_valid = 1; load_data = 9'($urandom); load_last = end_last && (i == n-1);
      prog[i] = load_data;
      step();
    end
    load_valid = 0; load_last = 0; step();
  endtask

  task automatic fetch(input int a);
    stall = 0; fetch_en = 1; prog_ctr_out = 12'(a); step();
  endtask

  initial begin
    logic [W-1:0] w0, w1, w2;
    w0 = 9'b001111110; w1 = 9'b001100110; w2 = 9'b111011110;
    step(); chk_on = 1; step();
    reset_n = 1; fetch_en = 1; prog_ctr_out = '0; step();
    chk("rst_fv", int'(fetch_valid), 0);
    chk("rst_mc", int'(mach_code), int'(NOP));
    chk("rst_loaded", int'(prog_loaded), 0);
    chk("rst_ready", int'(load_ready), 0);
    fetch_en = 0;

    start_load();
    chk("ready_in_load", int'(load_ready), 1);
    load_valid = 1; load_data = w0; step();
    load_data = w1; step();
    load_data = w2; load_last = 1; step();
    load_valid = 0; load_last = 0;
    chk("basic_len", int'(prog_len), 3);
    chk("basic_loaded", int'(prog_loaded), 1);
    chk("basic_ovf", int'(load_ovf), 0);
    fetch(0); chk("f0", int'(mach_code), int'(w0)); chk("f0_v", int'(fetch_valid), 1);
    fetch(1); chk("f1", int'(mach_code), int'(w1));
    fetch(2); chk("f2", int'(mach_code), int'(w2)); chk("f2_oob", int'(fetch_oob), 0);
    fetch(3); chk("oob3", int'(mach_code), int'(NOP)); chk("oob3_f", int'(fetch_oob), 1);
    chk("oob3_v", int'(fetch_valid), 1);
    fetch(4095); chk("oob4095_f", int'(fetch_oob), 1);
    fetch_en = 0; step(); chk("idle_fv", int'(fetch_valid), 0);
    chk("idle_hold", int'(mach_code), int'(NOP));

    start_load(); load_words(20, 1, 1);
    chk("bp_len", int'(prog_len), 20);
    for (int i = 0; i < 20; i++) fetch(i);
    fetch(5); chk("st_pre", int'(mach_code), int'(prog[5]));
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      prog_ctr_out = 12'($urandom); fetch_en = 1'($urandom); step();
      chk("st_hold", int'(mach_code), int'(prog[5])); chk("st_fv", int'(fetch_valid), 1);
    end
    fetch(7); chk("st_rel", int'(mach_code), int'(prog[7]));
    rnd = 1; repeat (200) step(); rnd = 0; stall = 0;

    fetch_en = 1; prog_ctr_out = 1; load_start = 1; step(); load_start = 0;
    chk("ls_fv", int'(fetch_valid), 0);
    rnd = 1; load_words(DEPTH, 0, 0); rnd = 0;
    chk("ovf", int'(load_ovf), 1); chk("ovf_len", int'(prog_len), DEPTH);
    chk("ovf_loaded", int'(prog_loaded), 1);
    load_valid = 1; load_last = 1; step(); load_valid = 0; load_last = 0;
    chk("ovf_ignored", int'(prog_len), DEPTH);
    fetch(4095); chk("top_word", int'(mach_code), int'(prog[4095]));
    chk("top_oob", int'(fetch_oob), 0);

    start_load(); load_words(DEPTH, 1, 0);
    chk("full_last_ovf", int'(load_ovf), 0); chk("full_last_len", int'(prog_len), DEPTH);

    start_load(); load_words(5, 1, 1);
    stall = 1; fetch_en = 1; step();
    load_start = 1; step(); load_start = 0; stall = 0; fetch_en = 0;
    chk("ls_stall_fv", int'(fetch_valid), 0);
    load_words(3, 0, 0); start_load(); load_words(2, 1, 0);
    chk("reload_len", int'(prog_len), 2);
    fetch(3); chk("reload_oob", int'(fetch_oob), 1);
    rnd = 1; repeat (100) step(); rnd = 0; stall = 0;

    start_load(); load_valid = 1; step(); step();
    reset_n = 0; step(); reset_n = 1; load_valid = 0;
    chk("mid_rst_ready", int'(load_ready), 0); chk("mid_rst_len", int'(prog_len), 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
